// File: rtl/instr_encoder_if.sv
// ------------------------------------------------------------------
// instr_encoder_if : bundle-in / memory-write-out bus of instr_encoder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

interface instr_encoder_if;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        kind;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [12:0] imm;
  logic        last;
  logic        wr_en;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        done;
  logic        full;
  logic        err;
  logic [8:0]  count;

  modport master (
    output start, in_valid, kind, rd, rs1, rs2, imm, last, wr_ready,
    input  in_ready, wr_en, wr_addr, wr_data, done, full, err, count
  );

  modport slave (
    input  start, in_valid, kind, rd, rs1, rs2, imm, last, wr_ready,
    output in_ready, wr_en, wr_addr, wr_data, done, full, err, count
  );
endinterface

`default_nettype wire

// File: rtl/instr_encoder.sv
// ------------------------------------------------------------------
// instr_encoder : encodes addi/bne bundles into RV32I words for imem load
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module instr_encoder (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        pend_valid;
  logic        pend_last;
  logic [7:0]  addr;
  logic [31:0] data;
  logic [8:0]  word_count;
  logic        err_flag;
  logic        full_flag;

  logic        in_ready;
  logic        accept;
  logic        complete;
  logic        term_pending;
  logic        illegal;
  logic [31:0] enc;

  // A pending write that ends the session (last or top address) blocks intake.
  always_comb begin
    state_next   = state;
    complete     = pend_valid && bus.wr_ready;
    term_pending = pend_valid && (pend_last || addr == 8'hFF);
    in_ready     = (state == RUN) && !term_pending && (!pend_valid || bus.wr_ready);
    accept       = in_ready && bus.in_valid;
    illegal      = bus.kind ? bus.imm[0] : (bus.imm[12] != bus.imm[11]);
    enc          = bus.kind
                 ? {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, 3'b001,
                    bus.imm[4:1], bus.imm[11], 7'b1100011}
                 : {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b0010011};
    case (state)
      IDLE, DONE: begin
        if (bus.start) state_next = RUN;
      end
      RUN: begin
        if (complete && term_pending)
          state_next = DONE;
        else if (accept && illegal && bus.last)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_last  <= 1'b0;
      addr       <= 8'd0;
      data       <= 32'd0;
      word_count <= 9'd0;
      err_flag   <= 1'b0;
      full_flag  <= 1'b0;
    end else if (state != RUN) begin
      if (bus.start) begin
        addr       <= 8'd0;
        word_count <= 9'd0;
        err_flag   <= 1'b0;
        full_flag  <= 1'b0;
      end
    end else begin
      if (complete) begin
        pend_valid <= 1'b0;
        addr       <= addr + 8'd1;
        word_count <= word_count + 9'd1;
        if (addr == 8'hFF) full_flag <= 1'b1;
      end
      // Illegal bundles are consumed but never reach the memory side.
      if (accept) begin
        if (illegal) begin
          err_flag <= 1'b1;
        end else begin
          pend_valid <= 1'b1;
          pend_last  <= bus.last;
          data       <= enc;
        end
      end
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = pend_valid;
  assign bus.wr_addr  = addr;
  assign bus.wr_data  = data;
  assign bus.count    = word_count;
  assign bus.err      = err_flag;
  assign bus.full     = full_flag;
  assign bus.done     = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ------------------------------------------------------------------
// tb_instr_encoder : randomized self-checking bench for instr_encoder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_instr_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  instr_encoder_if bus ();

  instr_encoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t seen[$];
  wr_t exp_q[$];

  // Completed writes, sampled mid-cycle while inputs are stable.
  always @(negedge clk)
    if (rst_n && bus.wr_en === 1'b1 && bus.wr_ready === 1'b1)
      seen.push_back({bus.wr_addr, bus.wr_data});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoding computed from the field rules with plain arithmetic.
  function automatic logic [31:0] model_word(input bit k, input logic [4:0] d,
                                             input logic [4:0] s1, input logic [4:0] s2,
                                             input int off);
    logic [31:0] u;
    logic [31:0] w;
    u = 32'(off) & 32'h1FFF;
    if (!k)
      w = ((u & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(d) << 7) | 32'h13;
    else
      w = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25)
        | (32'(s2) << 20) | (32'(s1) << 15) | 32'h1000
        | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7) | 32'h63;
    return w;
  endfunction

  function automatic bit model_legal(input bit k, input int off);
    if (!k) return (off >= -2048) && (off <= 2047);
    return (off & 1) == 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Presents one bundle until accepted; wr_ready is re-drawn every cycle.
  task automatic send(input bit k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [12:0] im, input bit l,
                      input int pct);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.kind = k; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im; bus.last = l;
    forever begin
      bus.wr_ready = ($urandom_range(99) < pct);
      #1;
      if (bus.in_ready === 1'b1) begin
        tick();
        break;
      end
      tick();
      waited++;
      if (waited > 64) begin
        n_cmp++; n_fail++;
        $display("FAIL send_timeout: in_ready=%b after %0d cycles, want 1", bus.in_ready, waited);
        break;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int pct);
    int n = 0;
    while (bus.done !== 1'b1 && n < 200) begin
      bus.wr_ready = ($urandom_range(99) < pct);
      tick();
      n++;
    end
    n_cmp++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_timeout: done=%b want 1", bus.done);
    end
  endtask

  task automatic test_reset();
    logic [31:0] got [8];
    string       nm  [8];
    #2 rst_n = 1'b0;
    tick(); tick();
    nm  = '{"wr_en", "wr_addr", "wr_data", "count", "done", "full", "err", "in_ready"};
    got = '{32'(bus.wr_en), 32'(bus.wr_addr), bus.wr_data, 32'(bus.count),
            32'(bus.done), 32'(bus.full), 32'(bus.err), 32'(bus.in_ready)};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_%s: got %h want 0", nm[i], got[i]);
      end
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1; bus.wr_ready = 1'b1; bus.imm = 13'd1; bus.last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_hold: in_ready=%b wr_en=%b done=%b want 0/0/0",
                 bus.in_ready, bus.wr_en, bus.done);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_basic_addi();
    do_start();
    send(1'b0, 5'd1, 5'd0, 5'd0, 13'd5, 1'b1, 100);
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd0 || bus.wr_data !== 32'h00500093) begin
      n_fail++;
      $display("FAIL basic_write: wr_en=%b addr=%0d data=%h want 1/0/00500093",
               bus.wr_en, bus.wr_addr, bus.wr_data);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.count !== 9'd1 || bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b count=%0d wr_en=%b want 1/1/0",
               bus.done, bus.count, bus.wr_en);
    end
  endtask

  task automatic test_signed();
    do_start();
    seen.delete();
    send(1'b0, 5'd1, 5'd0, 5'd0, 13'h1FFF, 1'b0, 100);
    send(1'b1, 5'd0, 5'd1, 5'd2, 13'h1FFC, 1'b1, 100);
    drain(100);
    n_cmp++;
    if (seen.size() != 2) begin
      n_fail++;
      $display("FAIL signed_count: got %0d writes want 2", seen.size());
    end else begin
      n_cmp++;
      if (seen[0] !== {8'd0, 32'hFFF00093} || seen[1] !== {8'd1, 32'hFE209EE3}) begin
        n_fail++;
        $display("FAIL signed_words: got %h,%h want 00FFF00093,01FE209EE3", seen[0], seen[1]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] wa, wb;
    wa = model_word(1'b0, 5'd3, 5'd4, 5'd0, 100);
    wb = model_word(1'b1, 5'd0, 5'd7, 5'd9, -256);
    do_start();
    send(1'b0, 5'd3, 5'd4, 5'd0, 13'd100, 1'b0, 0);
    bus.in_valid = 1'b1;
    bus.kind = 1'b1; bus.rd = 5'd0; bus.rs1 = 5'd7; bus.rs2 = 5'd9;
    bus.imm = 13'(-256); bus.last = 1'b1; bus.wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd0 || bus.wr_data !== wa || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: wr_en=%b addr=%0d data=%h in_ready=%b want 1/0/%h/0",
                 i, bus.wr_en, bus.wr_addr, bus.wr_data, bus.in_ready, wa);
      end
      tick();
    end
    bus.wr_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release_ready: in_ready=%b want 1", bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd1 || bus.wr_data !== wb) begin
      n_fail++;
      $display("FAIL bp_next: wr_en=%b addr=%0d data=%h want 1/1/%h",
               bus.wr_en, bus.wr_addr, bus.wr_data, wb);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.count !== 9'd2) begin
      n_fail++;
      $display("FAIL bp_done: done=%b count=%0d want 1/2", bus.done, bus.count);
    end
  endtask

  task automatic test_illegal();
    logic [31:0] w;
    w = model_word(1'b1, 5'd0, 5'd4, 5'd5, 8);
    do_start();
    seen.delete();
    send(1'b1, 5'd0, 5'd2, 5'd3, 13'd3, 1'b0, 100);
    n_cmp++;
    if (bus.err !== 1'b1 || bus.wr_en !== 1'b0 || bus.count !== 9'd0) begin
      n_fail++;
      $display("FAIL illegal_bne: err=%b wr_en=%b count=%0d want 1/0/0", bus.err, bus.wr_en, bus.count);
    end
    send(1'b0, 5'd1, 5'd2, 5'd0, 13'h0800, 1'b0, 100);
    send(1'b0, 5'd6, 5'd7, 5'd0, 13'h1000, 1'b0, 100);
    n_cmp++;
    if (bus.err !== 1'b1 || bus.wr_en !== 1'b0 || bus.count !== 9'd0 || bus.wr_addr !== 8'd0) begin
      n_fail++;
      $display("FAIL illegal_addi: err=%b wr_en=%b count=%0d addr=%0d want 1/0/0/0",
               bus.err, bus.wr_en, bus.count, bus.wr_addr);
    end
    send(1'b1, 5'd0, 5'd4, 5'd5, 13'd8, 1'b1, 100);
    drain(100);
    n_cmp++;
    if (seen.size() != 1 || seen[0] !== {8'd0, w} || bus.count !== 9'd1 || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_follow: writes=%0d first=%h count=%0d err=%b want 1/00%h/1/1",
               seen.size(), (seen.size() > 0) ? seen[0] : 40'h0, bus.count, bus.err, w);
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    do_start();
    c0 = cyc;
    for (int i = 0; i < 8; i++)
      send(1'b0, 5'(i + 1), 5'(i), 5'd0, 13'(i * 3), (i == 7), 100);
    n_cmp++;
    if (cyc - c0 != 8) begin
      n_fail++;
      $display("FAIL b2b_cycles: took %0d cycles for 8 bundles want 8", cyc - c0);
    end
    tick();
    n_cmp++;
    if (bus.done !== 1'b1 || bus.count !== 9'd8) begin
      n_fail++;
      $display("FAIL b2b_done: done=%b count=%0d want 1/8", bus.done, bus.count);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 4; s++) begin
      int  n, off, pct, a;
      bit  k, any_bad;
      logic [4:0] d, s1, s2;
      do_start();
      n_cmp++;
      if (bus.count !== 9'd0 || bus.err !== 1'b0 || bus.full !== 1'b0 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_restart[%0d]: count=%0d err=%b full=%b done=%b want 0/0/0/0",
                 s, bus.count, bus.err, bus.full, bus.done);
      end
      seen.delete(); exp_q.delete();
      n = $urandom_range(40, 8);
      pct = (s == 0) ? 100 : $urandom_range(90, 30);
      a = 0; any_bad = 1'b0;
      for (int i = 0; i < n; i++) begin
        k   = 1'($urandom_range(1));
        d   = 5'($urandom_range(31));
        s1  = 5'($urandom_range(31));
        s2  = 5'($urandom_range(31));
        off = int'($urandom_range(8191)) - 4096;
        if (model_legal(k, off)) begin
          exp_q.push_back({8'(a), model_word(k, d, s1, s2, off)});
          a++;
        end else begin
          any_bad = 1'b1;
        end
        send(k, d, s1, s2, 13'(off), (i == n - 1), pct);
      end
      drain(pct);
      n_cmp++;
      if (seen.size() != exp_q.size() || bus.count !== 9'(exp_q.size()) || bus.err !== any_bad) begin
        n_fail++;
        $display("FAIL rnd_totals[%0d]: writes=%0d count=%0d err=%b want %0d/%0d/%b",
                 s, seen.size(), bus.count, bus.err, exp_q.size(), exp_q.size(), any_bad);
      end
      for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
        n_cmp++;
        if (seen[i] !== exp_q[i]) begin
          n_fail++;
          $display("FAIL rnd_word[%0d.%0d]: got %h want %h", s, i, seen[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int off;
    do_start();
    seen.delete();
    for (int i = 0; i < 256; i++) begin
      off = int'($urandom_range(4095)) - 2048;
      send(1'b0, 5'($urandom_range(31)), 5'($urandom_range(31)), 5'd0, 13'(off), 1'b0, 100);
    end
    n_cmp++;
    if (bus.wr_en !== 1'b1 || bus.wr_addr !== 8'd255 || bus.full !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_last: wr_en=%b addr=%0d full=%b in_ready=%b want 1/255/0/0",
               bus.wr_en, bus.wr_addr, bus.full, bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.full !== 1'b1 || bus.done !== 1'b1 || bus.count !== 9'd256 ||
        bus.wr_addr !== 8'd0 || bus.in_ready !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_end: full=%b done=%b count=%0d addr=%0d in_ready=%b wr_en=%b want 1/1/256/0/0/0",
               bus.full, bus.done, bus.count, bus.wr_addr, bus.in_ready, bus.wr_en);
    end
    n_cmp++;
    if (seen.size() != 256 || seen[255].a !== 8'd255) begin
      n_fail++;
      $display("FAIL wrap_writes: writes=%0d want 256 ending at address 255", seen.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] got [8];
    string       nm  [8];
    do_start();
    send(1'b0, 5'd2, 5'd3, 5'd0, 13'd7, 1'b0, 0);
    n_cmp++;
    if (bus.wr_en !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pending: wr_en=%b want 1", bus.wr_en);
    end
    #2 rst_n = 1'b0;
    #1;
    nm  = '{"wr_en", "wr_addr", "wr_data", "count", "done", "full", "err", "in_ready"};
    got = '{32'(bus.wr_en), 32'(bus.wr_addr), bus.wr_data, 32'(bus.count),
            32'(bus.done), 32'(bus.full), 32'(bus.err), 32'(bus.in_ready)};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (got[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL midrst_%s: got %h want 0", nm[i], got[i]);
      end
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    do_start();
    seen.delete();
    send(1'b0, 5'd9, 5'd1, 5'd0, 13'd42, 1'b1, 100);
    drain(100);
    n_cmp++;
    if (seen.size() != 1 || seen[0] !== {8'd0, model_word(1'b0, 5'd9, 5'd1, 5'd0, 42)}) begin
      n_fail++;
      $display("FAIL midrst_restart: writes=%0d first=%h want 1 write at address 0",
               seen.size(), (seen.size() > 0) ? seen[0] : 40'h0);
    end
  endtask

  initial begin
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.kind = 1'b0;
    bus.rd = 5'd0; bus.rs1 = 5'd0; bus.rs2 = 5'd0; bus.imm = 13'd0;
    bus.last = 1'b0; bus.wr_ready = 1'b0;
    test_reset();
    test_basic_addi();
    test_signed();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
